// File: rtl/game_round_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : game_round_ctrl_if
// Purpose  : Bundles the round controller's control inputs and status outputs.
//            master = start/button side, slave = round controller.
// Revision : 1.0  initial release
// ============================================================================
interface game_round_ctrl_if;
  logic        tick_i;
  logic        new_game_i;
  logic        score_clr_i;
  logic [3:0]  player_en_i;
  logic [8:0]  luc_loc0_i;
  logic [8:0]  luc_loc1_i;
  logic [8:0]  luc_loc2_i;
  logic [8:0]  luc_loc3_i;
  logic [3:0]  active_o;
  logic [3:0]  alive_o;
  logic        lines_run_o;
  logic        restart_o;
  logic [1:0]  state_o;
  logic [11:0] countdown_o;
  logic [1:0]  winner_o;
  logic        winner_valid_o;
  logic [15:0] score_o;

  modport master (
    output tick_i, new_game_i, score_clr_i, player_en_i,
    output luc_loc0_i, luc_loc1_i, luc_loc2_i, luc_loc3_i,
    input  active_o, alive_o, lines_run_o, restart_o, state_o,
    input  countdown_o, winner_o, winner_valid_o, score_o
  );

  modport slave (
    input  tick_i, new_game_i, score_clr_i, player_en_i,
    input  luc_loc0_i, luc_loc1_i, luc_loc2_i, luc_loc3_i,
    output active_o, alive_o, lines_run_o, restart_o, state_o,
    output countdown_o, winner_o, winner_valid_o, score_o
  );
endinterface
`default_nettype wire

// File: rtl/game_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : game_round_ctrl
// Purpose  : Round sequencer for the gravity-runner game: latches players on
//            a new-game press, counts down, runs the round while tracking
//            eliminations, declares the winner and keeps saturating scores.
// Revision : 1.0  initial release
// ============================================================================
module game_round_ctrl #(
  parameter int unsigned COUNTDOWN_TICKS = 3000,
  parameter int unsigned HOLD_TICKS      = 2000,
  parameter int unsigned MAX_LOC         = 440
) (
  input  wire              clk_i,
  input  wire              rst_i,
  game_round_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_COUNTDOWN = 2'd1,
    ST_RUN       = 2'd2,
    ST_OVER      = 2'd3
  } state_t;

  localparam logic [11:0] c_countdown_load = 12'(COUNTDOWN_TICKS);
  localparam logic [11:0] c_hold_load      = 12'(HOLD_TICKS);
  localparam logic [8:0]  c_max_loc        = 9'(MAX_LOC);

  state_t          state_q, state_d;
  logic [11:0]     count_q, count_d;
  logic [3:0]      active_q, active_d;
  logic [3:0]      alive_q, alive_d;
  logic            restart_q, restart_d;
  logic            lines_run_q, lines_run_d;
  logic [1:0]      winner_q, winner_d;
  logic            winner_valid_q, winner_valid_d;
  logic [3:0][3:0] score_q, score_d;
  logic            prev_q;

  logic            w_edge;
  logic            w_accept;
  logic            w_round_end;
  logic [3:0]      w_off;
  logic [2:0]      w_alive_cnt;
  logic [2:0]      w_active_cnt;
  logic [1:0]      w_alive_idx;

  function automatic logic [2:0] f_popcount(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  // Lowest set index; only used when exactly one bit is set.
  function automatic logic [1:0] f_low_index(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // Next-state logic: accepted press overrides everything, then per-state work.
  always_comb begin
    w_edge       = bus.new_game_i & ~prev_q;
    w_accept     = w_edge & (|bus.player_en_i);
    // Unsigned compare also catches wrapped (underflowed) locations >= 472.
    w_off        = {bus.luc_loc3_i > c_max_loc, bus.luc_loc2_i > c_max_loc,
                    bus.luc_loc1_i > c_max_loc, bus.luc_loc0_i > c_max_loc};
    w_alive_cnt  = f_popcount(alive_q);
    w_active_cnt = f_popcount(active_q);
    w_alive_idx  = f_low_index(alive_q);
    // Multi-player rounds end at one survivor; any round ends when nobody is left.
    w_round_end  = (w_alive_cnt == 3'd0) ||
                   ((w_active_cnt >= 3'd2) && (w_alive_cnt == 3'd1));

    state_d        = state_q;
    count_d        = count_q;
    active_d       = active_q;
    alive_d        = alive_q;
    restart_d      = 1'b0;
    winner_d       = winner_q;
    winner_valid_d = winner_valid_q;
    score_d        = score_q;

    if (w_accept) begin
      state_d        = ST_COUNTDOWN;
      count_d        = c_countdown_load;
      active_d       = bus.player_en_i;
      alive_d        = bus.player_en_i;
      restart_d      = 1'b1;
      winner_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.score_clr_i) score_d = '0;
        end
        ST_COUNTDOWN: begin
          if (bus.tick_i) begin
            if (count_q == 12'd1) begin
              state_d = ST_RUN;
              count_d = 12'd0;
            end else if (count_q != 12'd0) begin
              count_d = count_q - 12'd1;
            end
          end
        end
        ST_RUN: begin
          if (w_round_end) begin
            state_d = ST_OVER;
            count_d = c_hold_load;
            if (w_alive_cnt == 3'd1) begin
              winner_d       = w_alive_idx;
              winner_valid_d = 1'b1;
              if (score_q[w_alive_idx] != 4'hF) begin
                score_d[w_alive_idx] = score_q[w_alive_idx] + 4'd1;
              end
            end
          end else if (bus.tick_i) begin
            alive_d = alive_q & ~w_off;
          end
        end
        ST_OVER: begin
          if (bus.tick_i) begin
            if (count_q == 12'd1) begin
              state_d = ST_IDLE;
              count_d = 12'd0;
            end else if (count_q != 12'd0) begin
              count_d = count_q - 12'd1;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    lines_run_d = (state_d == ST_RUN);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q        <= ST_IDLE;
      count_q        <= 12'd0;
      active_q       <= 4'd0;
      alive_q        <= 4'd0;
      restart_q      <= 1'b0;
      lines_run_q    <= 1'b0;
      winner_q       <= 2'd0;
      winner_valid_q <= 1'b0;
      score_q        <= '0;
      prev_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      active_q       <= active_d;
      alive_q        <= alive_d;
      restart_q      <= restart_d;
      lines_run_q    <= lines_run_d;
      winner_q       <= winner_d;
      winner_valid_q <= winner_valid_d;
      score_q        <= score_d;
      prev_q         <= bus.new_game_i;
    end
  end

  assign bus.active_o       = active_q;
  assign bus.alive_o        = alive_q;
  assign bus.lines_run_o    = lines_run_q;
  assign bus.restart_o      = restart_q;
  assign bus.state_o        = state_q;
  assign bus.countdown_o    = count_q;
  assign bus.winner_o       = winner_q;
  assign bus.winner_valid_o = winner_valid_q;
  assign bus.score_o        = score_q;

endmodule
`default_nettype wire
